sdram_burst_scheduler: RTL and testbench

// Read-burst scheduler that shares the SDRAM master port (ar_*) among three read clients during play:
// PCM audio fetch (client 0), line buffer fill (client 1) and note/sprite fetch (client 2).

---
 rtl/sdram_burst_scheduler_pkg.sv | 23 ++
 rtl/sdram_burst_scheduler_if.sv | 14 +
 rtl/sdram_burst_scheduler_prio_pick.sv | 31 +++
 rtl/sdram_burst_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared types and constants for the SDRAM read-burst scheduler.
package sdram_sched_pkg;

    localparam int unsigned NUM_CLIENTS      = 3;
    localparam int unsigned SDRAM_AW         = 25;
    localparam int unsigned SDRAM_DW         = 16;
    localparam int unsigned DEF_MAX_BURST    = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 64;

    // Client slots on the req/gnt/rd_valid vectors
    localparam logic [1:0] CLIENT_PCM  = 2'd0;
    localparam logic [1:0] CLIENT_LB   = 2'd1;
    localparam logic [1:0] CLIENT_NOTE = 2'd2;

    typedef logic [NUM_CLIENTS-1:0] client_vec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sdram_burst_scheduler_if.sv
// Run-time SDRAM read port between the scheduler and the SDRAM arbiter.
interface sdram_burst_scheduler_if;
    import sdram_sched_pkg::*;

    logic [SDRAM_AW-1:0] ar_addr;
    logic [1:0]          ar_be;
    logic                ar_read;
    logic                ar_ac;
    logic [SDRAM_DW-1:0] ar_rddata;

    modport master (output ar_addr, ar_be, ar_read, input ar_ac, ar_rddata);
    modport slave  (input ar_addr, ar_be, ar_read, output ar_ac, ar_rddata);

endinterface

// File: rtl/sdram_burst_scheduler_prio_pick.sv
// Combinational burst winner: PCM first, then line buffer, then notes,
// except that a starving note client jumps ahead of the line buffer.
module sched_prio_pick
    import sdram_sched_pkg::*;
(
    input  logic        i_en,
    input  client_vec_t i_req,
    input  logic        i_starve,
    output client_vec_t o_win_c,
    output logic        o_valid_c
);

    // Fixed priority with starvation override for the note client
    always_comb begin
        o_win_c = '0;
        if (i_en) begin
            if (i_req[CLIENT_PCM]) begin
                o_win_c[CLIENT_PCM] = 1'b1;
            end else if (i_req[CLIENT_NOTE] && i_starve) begin
                o_win_c[CLIENT_NOTE] = 1'b1;
            end else if (i_req[CLIENT_LB]) begin
                o_win_c[CLIENT_LB] = 1'b1;
            end else if (i_req[CLIENT_NOTE]) begin
                o_win_c[CLIENT_NOTE] = 1'b1;
            end
        end
    end

    assign o_valid_c = |o_win_c;

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Non-preemptive read-burst scheduler sharing one SDRAM read port among
// PCM fetch, line-buffer fill and note/sprite fetch clients.
module sdram_burst_scheduler
    import sdram_sched_pkg::*;
#(
    parameter  int unsigned MAX_BURST    = DEF_MAX_BURST,
    parameter  int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int unsigned LEN_W        = $clog2(MAX_BURST) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    sched_en,
    input  logic [NUM_CLIENTS-1:0]                  req,
    input  logic [NUM_CLIENTS-1:0][SDRAM_AW-1:0]    req_addr,
    input  logic [NUM_CLIENTS-1:0][LEN_W-1:0]       req_len,
    output logic [NUM_CLIENTS-1:0]                  gnt,
    output logic [SDRAM_DW-1:0]                     rd_data,
    output logic [NUM_CLIENTS-1:0]                  rd_valid,
    output logic [NUM_CLIENTS-1:0]                  rd_done,
    output logic                                    busy,
    sdram_burst_scheduler_if.master                 ar
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    sched_state_t          r_state, w_state_nxt;
    client_vec_t           r_owner, w_owner_nxt;
    logic [SDRAM_AW-1:0]   r_cur_addr, w_cur_addr_nxt;
    logic [LEN_W-1:0]      r_rem, w_rem_nxt;
    logic [STARVE_W-1:0]   r_starve_cnt, w_starve_cnt_nxt;
    client_vec_t           r_gnt, w_gnt_nxt;
    client_vec_t           r_rd_valid, w_rd_valid_nxt;
    client_vec_t           r_rd_done, w_rd_done_nxt;
    logic [SDRAM_DW-1:0]   r_rd_data, w_rd_data_nxt;
    logic                  r_ar_read, w_ar_read_nxt;
    logic                  r_busy, w_busy_nxt;

    client_vec_t           w_win;
    logic                  w_win_valid;
    logic                  w_starve;
    logic                  w_fire;
    logic [SDRAM_AW-1:0]   w_sel_addr;
    logic [LEN_W-1:0]      w_sel_len;
    logic [LEN_W-1:0]      w_len_clamped;

    assign w_starve = (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));

    sched_prio_pick u_pick (
        .i_en      (sched_en),
        .i_req     (req),
        .i_starve  (w_starve),
        .o_win_c   (w_win),
        .o_valid_c (w_win_valid)
    );

    // A grant can only be issued between bursts (IDLE or the GAP cycle)
    assign w_fire = (r_state != S_BURST) && w_win_valid;

    // Select the winner's start address and length, then clamp the length to 1..MAX_BURST
    always_comb begin
        w_sel_addr = ({SDRAM_AW{w_win[CLIENT_PCM]}}  & req_addr[CLIENT_PCM])
                   | ({SDRAM_AW{w_win[CLIENT_LB]}}   & req_addr[CLIENT_LB])
                   | ({SDRAM_AW{w_win[CLIENT_NOTE]}} & req_addr[CLIENT_NOTE]);
        w_sel_len  = ({LEN_W{w_win[CLIENT_PCM]}}  & req_len[CLIENT_PCM])
                   | ({LEN_W{w_win[CLIENT_LB]}}   & req_len[CLIENT_LB])
                   | ({LEN_W{w_win[CLIENT_NOTE]}} & req_len[CLIENT_NOTE]);
        if (w_sel_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (w_sel_len > LEN_W'(MAX_BURST)) begin
            w_len_clamped = LEN_W'(MAX_BURST);
        end else begin
            w_len_clamped = w_sel_len;
        end
    end

    // Next-state and next-output logic for the burst FSM and return path.
    // The grant cycle sits in BURST with ar_read still low, so ar_read
    // follows gnt by one cycle; GAP may grant again to keep len+2 spacing.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_cur_addr_nxt = r_cur_addr;
        w_rem_nxt      = r_rem;
        w_gnt_nxt      = '0;
        w_rd_valid_nxt = '0;
        w_rd_done_nxt  = '0;
        w_rd_data_nxt  = r_rd_data;
        w_ar_read_nxt  = r_ar_read;
        w_busy_nxt     = r_busy;

        case (r_state)
            S_IDLE, S_GAP: begin
                w_ar_read_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
                if (w_fire) begin
                    w_state_nxt    = S_BURST;
                    w_owner_nxt    = w_win;
                    w_cur_addr_nxt = w_sel_addr;
                    w_rem_nxt      = w_len_clamped;
                    w_gnt_nxt      = w_win;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_BURST: begin
                w_busy_nxt = 1'b1;
                if (!r_ar_read) begin
                    w_ar_read_nxt = 1'b1;
                end else if (ar.ar_ac) begin
                    w_cur_addr_nxt = r_cur_addr + SDRAM_AW'(1);
                    w_rem_nxt      = r_rem - LEN_W'(1);
                    w_rd_valid_nxt = r_owner;
                    w_rd_data_nxt  = ar.ar_rddata;
                    if (r_rem == LEN_W'(1)) begin
                        w_rd_done_nxt = r_owner;
                        w_ar_read_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_state_nxt   = S_GAP;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Note-client wait counter: saturates at the limit, cleared when client 2 wins
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_fire && w_win[CLIENT_NOTE]) begin
            w_starve_cnt_nxt = '0;
        end else if (req[CLIENT_NOTE] && !w_starve) begin
            w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context, starvation counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= '0;
            r_cur_addr   <= '0;
            r_rem        <= '0;
            r_starve_cnt <= '0;
            r_gnt        <= '0;
            r_rd_valid   <= '0;
            r_rd_done    <= '0;
            r_rd_data    <= '0;
            r_ar_read    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_rem        <= w_rem_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_rd_done    <= w_rd_done_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_ar_read    <= w_ar_read_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign rd_valid   = r_rd_valid;
    assign rd_done    = r_rd_done;
    assign rd_data    = r_rd_data;
    assign busy       = r_busy;
    assign ar.ar_read = r_ar_read;
    assign ar.ar_addr = r_cur_addr;
    assign ar.ar_be   = 2'b11;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler with a simple SDRAM responder
// whose read data is the low address bits XOR 16'h5A5A.
module tb_sdram_burst_scheduler;
    import sdram_sched_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              sched_en;
    logic              tb_ac;
    logic [2:0]        req;
    logic [2:0][24:0]  req_addr;
    logic [2:0][5:0]   req_len;
    logic [2:0]        gnt;
    logic [2:0]        rd_valid;
    logic [2:0]        rd_done;
    logic [15:0]       rd_data;
    logic              busy;

    int n_vec;
    int n_err;

    int          g_cyc [3];
    logic [2:0]  g_val [3];
    int          ng;
    int          nrd;
    int          rv_cnt [3];
    int          n1;
    int          first2;
    int          after1;
    int          ngnt;
    logic [24:0] exp_a [3];
    logic [24:0] a6;

    sdram_burst_scheduler_if sif ();

    assign sif.ar_ac     = tb_ac;
    assign sif.ar_rddata = sif.ar_addr[15:0] ^ 16'h5A5A;

    sdram_burst_scheduler dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sched_en (sched_en),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_done  (rd_done),
        .busy     (busy),
        .ar       (sif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_gnt"},      32'(gnt),         32'h0);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid),    32'h0);
        check_eq({tag, "_rd_done"},  32'(rd_done),     32'h0);
        check_eq({tag, "_rd_data"},  32'(rd_data),     32'h0);
        check_eq({tag, "_ar_read"},  32'(sif.ar_read), 32'h0);
        check_eq({tag, "_ar_addr"},  32'(sif.ar_addr), 32'h0);
        check_eq({tag, "_busy"},     32'(busy),        32'h0);
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        sched_en = 1'b1;
        tb_ac    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        n_vec    = 0;
        n_err    = 0;

        tick;
        tick;
        check_reset_outs("por");
        check_eq("ar_be", 32'(sif.ar_be), 32'h3);
        reset_n = 1'b1;
        tick;

        // Async reset in the middle of a line-buffer burst
        req_addr[1] = 25'h40;
        req_len[1]  = 6'd8;
        req         = 3'b010;
        tick;
        check_eq("t1_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick;
        tick;
        tick;
        check_eq("t1_pre_read", 32'(sif.ar_read), 32'h1);
        check_eq("t1_pre_valid", 32'(rd_valid), 32'h2);
        #3 reset_n = 1'b0;
        #1 check_reset_outs("t1_async");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check_eq("t1_post_valid", 32'(rd_valid), 32'h0);
            check_eq("t1_post_read", 32'(sif.ar_read), 32'h0);
            check_eq("t1_post_busy", 32'(busy), 32'h0);
        end

        // Single line-buffer burst of 4 at 0x100
        req_addr[1] = 25'h100;
        req_len[1]  = 6'd4;
        req         = 3'b010;
        tick;
        check_eq("t2_gnt", 32'(gnt), 32'h2);
        check_eq("t2_gnt_read", 32'(sif.ar_read), 32'h0);
        req = '0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            check_eq("t2_gnt_pulse", 32'(gnt), 32'h0);
            check_eq("t2_ar_read", 32'(sif.ar_read), (k <= 4) ? 32'h1 : 32'h0);
            if (k <= 4) check_eq("t2_ar_addr", 32'(sif.ar_addr), 32'h100 + 32'(k - 1));
            check_eq("t2_rd_valid", 32'(rd_valid), (k >= 2) ? 32'h2 : 32'h0);
            if (k >= 2) check_eq("t2_rd_data", 32'(rd_data), 32'(16'(32'h100 + 32'(k - 2)) ^ 16'h5A5A));
            check_eq("t2_rd_done", 32'(rd_done), (k == 5) ? 32'h2 : 32'h0);
            check_eq("t2_busy", 32'(busy), (k <= 4) ? 32'h1 : 32'h0);
        end
        tick;

        // Address wrap at the top of the 25-bit space, len 3
        exp_a[0] = 25'h1FFFFFE;
        exp_a[1] = 25'h1FFFFFF;
        exp_a[2] = 25'h0000000;
        req_addr[0] = 25'h1FFFFFE;
        req_len[0]  = 6'd3;
        req         = 3'b001;
        tick;
        check_eq("t5_gnt", 32'(gnt), 32'h1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq("t5_ar_read", 32'(sif.ar_read), 32'h1);
            check_eq("t5_ar_addr", 32'(sif.ar_addr), 32'(exp_a[k]));
        end
        tick;
        check_eq("t5_rd_done", 32'(rd_done), 32'h1);
        check_eq("t5_last_data", 32'(rd_data), 32'h5A5A);
        tick;
        tick;

        // All three clients request together
        req_addr[0] = 25'h10;  req_len[0] = 6'd2;
        req_addr[1] = 25'h200; req_len[1] = 6'd3;
        req_addr[2] = 25'h300; req_len[2] = 6'd1;
        for (int i = 0; i < 3; i++) begin
            g_cyc[i]  = -1;
            g_val[i]  = '0;
            rv_cnt[i] = 0;
        end
        ng  = 0;
        nrd = 0;
        req = 3'b111;
        for (int k = 0; k < 14; k++) begin
            tick;
            if (gnt != 3'b000) begin
                if (ng < 3) begin
                    g_cyc[ng] = k;
                    g_val[ng] = gnt;
                end
                ng++;
                req = req & ~gnt;
            end
            if (sif.ar_read) nrd++;
            for (int c = 0; c < 3; c++) rv_cnt[c] += int'(rd_valid[c]);
        end
        check_eq("t3_num_gnt", 32'(ng), 32'd3);
        check_eq("t3_gnt0_val", 32'(g_val[0]), 32'h1);
        check_eq("t3_gnt0_cyc", 32'(g_cyc[0]), 32'd0);
        check_eq("t3_gnt1_val", 32'(g_val[1]), 32'h2);
        check_eq("t3_gnt1_cyc", 32'(g_cyc[1]), 32'd4);
        check_eq("t3_gnt2_val", 32'(g_val[2]), 32'h4);
        check_eq("t3_gnt2_cyc", 32'(g_cyc[2]), 32'd9);
        check_eq("t3_ar_read_cycles", 32'(nrd), 32'd6);
        check_eq("t3_words_c0", 32'(rv_cnt[0]), 32'd2);
        check_eq("t3_words_c1", 32'(rv_cnt[1]), 32'd3);
        check_eq("t3_words_c2", 32'(rv_cnt[2]), 32'd1);
        tick;
        tick;

        // Starvation: line buffer hogs, note client must break through
        req_addr[1] = 25'h400; req_len[1] = 6'd8;
        req_addr[2] = 25'h500; req_len[2] = 6'd2;
        n1     = 0;
        first2 = -1;
        after1 = -1;
        req    = 3'b110;
        for (int k = 1; k <= 100; k++) begin
            tick;
            if (gnt[2]) begin
                if (first2 < 0) begin
                    first2 = k;
                    check_eq("t4_starve_clr", 32'(dut.r_starve_cnt), 32'h0);
                end
                req[2] = 1'b0;
            end
            if (gnt[1]) begin
                if (first2 < 0) n1++;
                else if (after1 < 0) after1 = k;
            end
        end
        check_eq("t4_gnt2_cyc", 32'(first2), 32'd71);
        check_eq("t4_lb_grants_before", 32'(n1), 32'd7);
        check_eq("t4_lb_resume_cyc", 32'(after1), 32'd75);
        req = '0;
        repeat (12) tick;
        check_eq("t4_idle_busy", 32'(busy), 32'h0);
        check_eq("t4_starve_end", 32'(dut.r_starve_cnt), 32'h0);

        // Throttled accept, scheduler disabled mid-burst
        req_addr[0] = 25'h700;
        req_len[0]  = 6'd3;
        tb_ac    = 1'b0;
        sched_en = 1'b1;
        req      = 3'b001;
        tick;
        check_eq("t6_gnt", 32'(gnt), 32'h1);
        for (int k = 1; k <= 10; k++) begin
            tick;
            a6 = (k <= 3) ? 25'h700 : ((k <= 6) ? 25'h701 : 25'h702);
            check_eq("t6_ar_read", 32'(sif.ar_read), (k <= 9) ? 32'h1 : 32'h0);
            if (k <= 9) check_eq("t6_ar_addr", 32'(sif.ar_addr), 32'(a6));
            check_eq("t6_rd_valid", 32'(rd_valid), (k == 4 || k == 7 || k == 10) ? 32'h1 : 32'h0);
            check_eq("t6_rd_done", 32'(rd_done), (k == 10) ? 32'h1 : 32'h0);
            if (k == 4) check_eq("t6_rd_data", 32'(rd_data), 32'(16'h0700 ^ 16'h5A5A));
            if (k == 1) sched_en = 1'b0;
            tb_ac = (k == 3 || k == 6 || k == 9);
        end
        tb_ac = 1'b1;
        ngnt  = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (gnt != 3'b000) ngnt++;
        end
        check_eq("t6_no_gnt_disabled", 32'(ngnt), 32'd0);
        check_eq("t6_held_busy", 32'(busy), 32'h0);
        check_eq("t6_held_read", 32'(sif.ar_read), 32'h0);
        sched_en = 1'b1;
        tick;
        check_eq("t6_gnt_reenable", 32'(gnt), 32'h1);
        req = '0;
        repeat (6) tick;
        check_eq("t6_final_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
